uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter FREQ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all state changes on the rising edge.
REQ-003 SHALL have port arst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-005 SHALL have port baud_rate, input, 2 bits: rate select; 00=2400, 01=4800, 10=9600, 11=19200.
REQ-006 SHALL have port rx_data, output, 8 bits: last received byte.
REQ-007 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when a good frame completes.
REQ-008 SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit samples low.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; rx_s, the second flop output, is used for all decisions.
REQ-011 SHALL compute DIV_x = FREQ/(16*BAUD_x) with integer truncation, held as 16-bit constants; at 50 MHz these are 1302, 651, 325 and 162.
REQ-012 SHALL latch baud_rate into a 2-bit register on start detection; changes to baud_rate mid-frame have no effect until the next frame.
REQ-013 SHALL run a 16-bit prescaler only outside IDLE, counting 0..DIV-1; tick is asserted for one clk when the count equals DIV-1, after which the count wraps to 0.
REQ-014 SHALL hold the prescaler at 0 in IDLE.
REQ-015 SHALL use a 4-bit oversample counter os_cnt that increments on each tick and is cleared on every state transition.
REQ-016 SHALL implement the FSM states IDLE, START, DATA and STOP.
REQ-017 IDLE: detect start as a falling edge (rx_s previous=1, now=0); on detection go to START and latch the rate.
REQ-018 START: on the tick where os_cnt==7, if rx_s==0 go to DATA, otherwise treat it as a glitch and return to IDLE with no pulse.
REQ-019 DATA: on the tick where os_cnt==15, shift rx_s into the shift register LSB-first and increment a 3-bit bit counter; after the 8th bit go to STOP.
REQ-020 STOP: on the tick where os_cnt==15, load rx_data from the shift register and return to IDLE.
REQ-021 In STOP, if rx_s==1, rx_valid SHALL pulse in the same cycle rx_data updates.
REQ-022 In STOP, if rx_s==0, frame_err SHALL pulse, rx_data SHALL still update, and rx_valid SHALL stay low.
REQ-023 rx_valid and frame_err are mutually exclusive and never high for more than one clk.
REQ-024 After frame_err, IDLE SHALL re-arm only on a fresh falling edge, so a line held low (break) produces no further frames.
REQ-025 Latency: the rx_valid edge is 1 clk after the stop-bit mid-sample tick, nominally 9.5 bit times plus 3 clk (synchronizer and edge detect) after the rx falling edge.
REQ-026 rx_data SHALL hold its value between frames; the shift register is not visible externally.

Reset
REQ-027 While arst_n=0, all state SHALL clear asynchronously: FSM=IDLE, prescaler=0, os_cnt=0, bit counter=0, synchronizer flops=1, edge-history flop=1, rx_data=8'h00, rx_valid=0, frame_err=0, busy=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no rx_valid or frame_err pulse.
REQ-029 After reset release with rx low, no frame SHALL start until rx goes high and then falls.

Verification (FREQ=50_000_000; bit time at 9600 = 16*325 = 5200 clk)
REQ-030 baud_rate=10, send 8N1 byte 0xA5 -> exactly one rx_valid pulse, rx_data=8'hA5, frame_err never high, busy high for about 9.5 bit times.
REQ-031 Run back-to-back frames 0x00, 0xFF, 0x3C at each of the four rates -> three rx_valid pulses per rate with matching data and no lost frames.
REQ-032 baud_rate=10, send 0x81 with the stop bit driven low -> frame_err pulse, rx_valid=0, rx_data=8'h81; then hold rx low for 20 bit times -> no further pulses.
REQ-033 In IDLE, drive a 2000-clk low glitch at 9600 -> FSM returns to IDLE, busy drops, no pulses.
REQ-034 baud_rate=00, switch to 11 during the data bits of 0x5A -> frame still decodes as 0x5A at 2400; the next frame is decoded at 19200.
REQ-035 Assert arst_n=0 during bit 4 of a frame -> all outputs return to reset values immediately, no pulse; after release, the next valid frame 0x12 decodes correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and a runtime-selectable baud rate.
// Latency: rx_valid/frame_err one clk after the stop-bit mid-sample, about 9.5 bit times plus 3 clk after the start edge.
// Backpressure: none; rx_valid is a single-cycle pulse and rx_data holds until the next frame completes.
module uart_rx #(
    parameter int FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       rx,
    input  logic [1:0] baud_rate,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] DIV_2400  = 16'(FREQ / (16 * 2400));
    localparam logic [15:0] DIV_4800  = 16'(FREQ / (16 * 4800));
    localparam logic [15:0] DIV_9600  = 16'(FREQ / (16 * 9600));
    localparam logic [15:0] DIV_19200 = 16'(FREQ / (16 * 19200));

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        sync1;
    logic        rx_s;
    logic        rx_prev;
    logic [1:0]  settle;
    logic        armed;
    logic        start_det;

    logic [1:0]  rate_q;
    logic [15:0] div;
    logic [15:0] presc;
    logic        tick;
    logic [3:0]  os_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;

    logic        shift_en;
    logic        load_data;
    logic        good_frame;
    logic        bad_frame;

    // Synchronizer and edge history reset high so a released line reads as idle.
    // armed only sets once the chain holds real samples and the line has been seen
    // high, so a line held low through reset release never looks like a start edge.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            settle  <= 2'b00;
            armed   <= 1'b0;
        end else begin
            sync1   <= rx;
            rx_s    <= sync1;
            rx_prev <= rx_s;
            settle  <= {settle[0], 1'b1};
            if (settle[1] && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign start_det = armed && rx_prev && !rx_s;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rate_q <= 2'b00;
        end else if (state == IDLE && start_det) begin
            rate_q <= baud_rate;
        end
    end

    always_comb begin
        div = DIV_2400;
        case (rate_q)
            2'b00:   div = DIV_2400;
            2'b01:   div = DIV_4800;
            2'b10:   div = DIV_9600;
            default: div = DIV_19200;
        endcase
    end

    assign tick = (state != IDLE) && (presc == div - 16'd1);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            presc <= 16'd0;
        end else if (state == IDLE || tick) begin
            presc <= 16'd0;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shift_en   = 1'b0;
        load_data  = 1'b0;
        good_frame = 1'b0;
        bad_frame  = 1'b0;
        case (state)
            IDLE: begin
                if (start_det) begin
                    state_nxt = START;
                end
            end
            START: begin
                // Mid-start-bit check rejects short low glitches.
                if (tick && os_cnt == 4'd7) begin
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && os_cnt == 4'd15) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (tick && os_cnt == 4'd15) begin
                    load_data  = 1'b1;
                    good_frame = rx_s;
                    bad_frame  = !rx_s;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            os_cnt <= 4'd0;
        end else if (state_nxt != state) begin
            os_cnt <= 4'd0;
        end else if (tick) begin
            os_cnt <= os_cnt + 4'd1;
        end
    end

    // bit_cnt wraps back to 0 after the eighth bit, ready for the next frame.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
        end else if (state == IDLE) begin
            bit_cnt <= 3'd0;
        end else if (shift_en) begin
            bit_cnt <= bit_cnt + 3'd1;
            shift   <= {rx_s, shift[7:1]};
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= good_frame;
            frame_err <= bad_frame;
            if (load_data) begin
                rx_data <= shift;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
